// File: rtl/uart_tx_buf.sv
// UART transmitter with a small FIFO in front of it.
// Words pushed on P_DATA are queued and sent as frames:
// start bit, DATA_WIDTH data bits (LSB first), optional parity bit, then one or two stop bits.
// Frame settings are captured when a word is popped, so changing them mid-frame has no effect on that frame.
// fsm_state exposes the FSM encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) for debug.
module uart_tx_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [15:0]           DIV,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow,
    output logic [2:0]            fsm_state
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAST_IDX   = 4'(DATA_WIDTH-1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state, state_next;

    // Buffer storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  push_ok;
    logic                  pop;

    // Frame datapath, loaded at pop time
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_q;
    logic                  par_en_q;
    logic                  stop2_q;
    logic [15:0]           div_q;
    logic [15:0]           bit_cnt;
    logic [3:0]            bit_idx;
    logic                  stop_idx;
    logic                  bit_end;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign push_ok    = data_valid && !fifo_full;
    assign bit_end    = (bit_cnt == div_q);
    assign busy       = (state != S_IDLE);
    assign fsm_state  = state;

    // Buffer write; the storage itself is not reset, a push during reset is discarded
    always_ff @(posedge CLK) begin
        if (!RST && push_ok) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    // Pointers, occupancy and the sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A dropped push counts even if a pop frees a slot at the same edge
            if (data_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, pop request and serial line value
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        TX_OUT     = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                TX_OUT = 1'b0;
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                TX_OUT = shreg[0];
                if (bit_end && (bit_idx == LAST_IDX)) begin
                    state_next = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                TX_OUT = par_q;
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                TX_OUT = 1'b1;
                if (bit_end && (stop_idx || !stop2_q)) begin
                    // Chain straight into the next frame when more words are waiting
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame datapath: load on pop, then count bit periods and shift data
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            div_q    <= '0;
            par_q    <= 1'b0;
            shreg    <= '0;
        end else if (pop) begin
            shreg    <= mem[rd_ptr];
            par_q    <= (^mem[rd_ptr]) ^ PAR_TYP;
            par_en_q <= PAR_EN;
            stop2_q  <= STOP2;
            div_q    <= DIV;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else if (state != S_IDLE) begin
            if (bit_end) begin
                bit_cnt <= '0;
                if (state == S_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 4'd1;
                end
                if (state == S_STOP) begin
                    stop_idx <= 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the transmit buffer depth; power of two, 2..16.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-005 P_DATA  input  DATA_WIDTH  SHALL be the parallel word to transmit.
REQ-006 data_valid  input  1  SHALL be the push strobe, one word per high cycle.
REQ-007 PAR_EN  input  1  SHALL enable the parity bit when high.
REQ-008 PAR_TYP  input  1  SHALL select parity: 0 = even, 1 = odd.
REQ-009 STOP2  input  1  SHALL select stop bits: 0 = one, 1 = two.
REQ-010 DIV  input  16  SHALL set bit period to DIV+1 CLK cycles.
REQ-011 TX_OUT  output  1  SHALL be the serial line, idle high.
REQ-012 busy  output  1  SHALL be high while a frame is on the line.
REQ-013 fifo_full  output  1  SHALL be high when the buffer holds FIFO_DEPTH words.
REQ-014 fifo_empty  output  1  SHALL be high when the buffer holds zero words.
REQ-015 overflow  output  1  SHALL be a sticky flag for dropped pushes.

Function
REQ-016 A push SHALL be accepted when data_valid=1 and fifo_full=0 (registered value); the word is written at that edge.
REQ-017 A push while fifo_full=1 SHALL be dropped and SHALL set overflow at that edge, even if a pop occurs in the same cycle.
REQ-018 A simultaneous accepted push and pop SHALL leave the occupancy count unchanged; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-020 In IDLE with fifo_empty=0, the next edge SHALL pop the head word and enter START.
  - Latched at that edge: PAR_EN, PAR_TYP, STOP2, DIV.
  - Consequence: a word pushed into an empty buffer at edge N drives TX_OUT=0 from edge N+1.
REQ-021 Each state SHALL hold for (latched DIV)+1 cycles, timed by a 16-bit bit counter.
REQ-022 The START state SHALL drive TX_OUT=0.
REQ-023 The DATA state SHALL shift DATA_WIDTH bits out, LSB first.
REQ-024 The PARITY state SHALL be entered only when PAR_EN was latched high.
  - Even parity: XOR of the data bits.
  - Odd parity: inverted XOR of the data bits.
REQ-025 The STOP state SHALL drive TX_OUT=1 for one bit period, or two when STOP2 was latched high.
REQ-026 At the end of STOP, the FSM SHALL enter START directly (with no idle cycle) if fifo_empty=0, otherwise IDLE.
REQ-027 The busy output SHALL be high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-028 Changes to PAR_EN, PAR_TYP, STOP2 or DIV during a frame SHALL NOT affect that frame.
REQ-029 With DIV=0, the block SHALL send one bit per CLK cycle.
  - Frame length: 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 cycles.

Reset
REQ-030 When RST=1, the next edge SHALL apply the following, regardless of state (including mid-frame):
  - TX_OUT=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0.
  - Pointers and count cleared; FSM in IDLE.
REQ-031 A push asserted in the same cycle as RST SHALL be discarded.
REQ-032 Buffer storage contents SHALL NOT require reset.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
  - Basic frame: DIV=0, PAR_EN=0, STOP2=0, push 0xA5 -> TX_OUT from edge N+1 is 0,1,0,1,0,0,1,0,1,1; busy high for exactly 10 cycles.
  - Odd parity, two stop bits: DIV=3, PAR_EN=1, PAR_TYP=1, STOP2=1, push 0x0F -> each bit lasts 4 cycles; parity bit=1; 8 stop cycles high; frame length 48 cycles.
  - Back-to-back: DIV=0, push 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 10-cycle frames with no idle gap; busy stays high for 30 cycles; fifo_empty rises after the third pop.
  - Overflow: FIFO_DEPTH=4, DIV=15, push 6 words on consecutive cycles -> first word popped, 4 buffered, fifo_full=1, sixth word dropped, overflow=1 and sticky; transmitted words are the first five in order.
  - Reset mid-operation: assert RST during DATA of the second frame -> after one edge TX_OUT=1, busy=0, fifo_empty=1, overflow=0; no further frames sent.
  - Mid-frame configuration change: change DIV from 1 to 7 mid-frame -> current frame keeps 2-cycle bits; the next frame uses 8-cycle bits.
